// File: rtl/tc_counter11_pkg.sv
// Shared definitions for the tc_counter11 terminal-count counter:
// the controller state encoding and the default counter width.
package tc_counter11_pkg;

  localparam int DEFAULT_WIDTH = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STOP = 2'b10
  } state_e;

endpackage

// File: rtl/tc_counter11_allones_dec.sv
// All-ones decoder: a WIDTH-input AND, used to detect terminal count.
module m_allones_dec #(
  parameter int WIDTH = 11
) (
  input  logic [WIDTH-1:0] in_i,
  output logic             all_ones_o
);

  assign all_ones_o = &in_i;

endmodule

// File: rtl/tc_counter11.sv
// Loadable up-counter with free-run / one-shot terminal-count handling,
// a registered terminal-count pulse and a sticky one-shot DONE flag.
module tc_counter11
  import tc_counter11_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter bit RELOAD_ON_WRAP = 1'b1
) (
  input  logic             MasterClock,
  input  logic             RESETL,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic             MODE,
  input  logic             CLRDONE,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             TCPULSE,
  output logic             DONE,
  output logic             RUNNING
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tcPulse_q, tcPulse_d;
  logic             done_q, done_d;
  logic             allOnes;

  m_allones_dec #(
    .WIDTH(WIDTH)
  ) uAllOnesDec (
    .in_i      (count_q),
    .all_ones_o(allOnes)
  );

  // Next-state decode: LD beats everything (and so masks any terminal-count
  // side effects); otherwise only RUN with EN advances. DONE set beats clear.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    tcPulse_d = 1'b0;
    done_d    = done_q & ~CLRDONE;
    if (LD) begin
      count_d  = D;
      reload_d = D;
      state_d  = ST_RUN;
    end else if ((state_q == ST_RUN) && EN) begin
      if (!allOnes) begin
        count_d = count_q + WIDTH'(1);
      end else if (!MODE) begin
        count_d   = RELOAD_ON_WRAP ? reload_q : '0;
        tcPulse_d = 1'b1;
      end else begin
        state_d   = ST_STOP;
        done_d    = 1'b1;
        tcPulse_d = 1'b1;
      end
    end
  end

  // All state registers, cleared asynchronously by RESETL.
  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      tcPulse_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      tcPulse_q <= tcPulse_d;
      done_q    <= done_d;
    end
  end

  assign Q       = count_q;
  assign TC      = allOnes;
  assign TCPULSE = tcPulse_q;
  assign DONE    = done_q;
  assign RUNNING = (state_q == ST_RUN);

endmodule

// File: tb/tb_tc_counter11.sv
// Directed, table-driven bench for tc_counter11 (WIDTH=11, RELOAD_ON_WRAP=1).
module tb_tc_counter11;

  logic        MasterClock;
  logic        RESETL;
  logic        LD;
  logic [10:0] D;
  logic        EN;
  logic        MODE;
  logic        CLRDONE;
  logic [10:0] Q;
  logic        TC;
  logic        TCPULSE;
  logic        DONE;
  logic        RUNNING;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic        ld;
    logic [10:0] d;
    logic        en;
    logic        mode;
    logic        clrDone;
    logic [10:0] expQ;
    logic        expTc;
    logic        expPulse;
    logic        expDone;
    logic        expRun;
  } vec_t;

  vec_t vecs[$];

  tc_counter11 #(
    .WIDTH(11),
    .RELOAD_ON_WRAP(1'b1)
  ) dut (
    .MasterClock(MasterClock),
    .RESETL     (RESETL),
    .LD         (LD),
    .D          (D),
    .EN         (EN),
    .MODE       (MODE),
    .CLRDONE    (CLRDONE),
    .Q          (Q),
    .TC         (TC),
    .TCPULSE    (TCPULSE),
    .DONE       (DONE),
    .RUNNING    (RUNNING)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    MasterClock = 1'b0;
    forever #5 MasterClock = ~MasterClock;
  end

  function automatic vec_t mk(logic ld, logic [10:0] d, logic en, logic mode, logic clrDone,
                              logic [10:0] expQ, logic expPulse, logic expDone, logic expRun);
    vec_t v;
    v.ld = ld; v.d = d; v.en = en; v.mode = mode; v.clrDone = clrDone;
    v.expQ = expQ; v.expTc = (expQ == 11'h7FF); v.expPulse = expPulse;
    v.expDone = expDone; v.expRun = expRun;
    return v;
  endfunction

  task automatic applyStimulus(input logic ld, input logic [10:0] d, input logic en,
                               input logic mode, input logic clrDone);
    LD = ld; D = d; EN = en; MODE = mode; CLRDONE = clrDone;
  endtask

  task automatic checkOne(input string tag, input string sig, input logic [10:0] got,
                          input logic [10:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s %s: got %h expected %h", tag, sig, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [10:0] expQ, input logic expTc,
                             input logic expPulse, input logic expDone, input logic expRun);
    checkOne(tag, "Q", Q, expQ);
    checkOne(tag, "TC", {10'd0, TC}, {10'd0, expTc});
    checkOne(tag, "TCPULSE", {10'd0, TCPULSE}, {10'd0, expPulse});
    checkOne(tag, "DONE", {10'd0, DONE}, {10'd0, expDone});
    checkOne(tag, "RUNNING", {10'd0, RUNNING}, {10'd0, expRun});
  endtask

  initial begin
    // ld d en mode clr | Q pulse done run   (state after one rising edge)
    vecs.push_back(mk(1, 11'h005, 1, 0, 0, 11'h005, 0, 0, 1)); // load from IDLE
    vecs.push_back(mk(0, 11'h000, 0, 0, 0, 11'h005, 0, 0, 1)); // EN low holds
    vecs.push_back(mk(0, 11'h000, 1, 0, 0, 11'h006, 0, 0, 1));
    vecs.push_back(mk(1, 11'h7FC, 1, 0, 0, 11'h7FC, 0, 0, 1)); // free-run wrap sequence
    vecs.push_back(mk(0, 11'h000, 1, 1, 0, 11'h7FD, 0, 0, 1)); // MODE ignored mid-count
    vecs.push_back(mk(0, 11'h000, 1, 0, 0, 11'h7FE, 0, 0, 1));
    vecs.push_back(mk(0, 11'h000, 1, 0, 0, 11'h7FF, 0, 0, 1));
    vecs.push_back(mk(0, 11'h000, 1, 0, 0, 11'h7FC, 1, 0, 1)); // wrap to reload, pulse
    vecs.push_back(mk(0, 11'h000, 1, 0, 0, 11'h7FD, 0, 0, 1)); // pulse is one cycle
    vecs.push_back(mk(1, 11'h7FE, 1, 1, 0, 11'h7FE, 0, 0, 1)); // one-shot
    vecs.push_back(mk(0, 11'h000, 1, 1, 0, 11'h7FF, 0, 0, 1));
    vecs.push_back(mk(0, 11'h000, 1, 1, 0, 11'h7FF, 1, 1, 0)); // STOP, DONE set
    vecs.push_back(mk(0, 11'h000, 1, 1, 0, 11'h7FF, 0, 1, 0)); // EN ignored in STOP
    vecs.push_back(mk(0, 11'h000, 1, 0, 1, 11'h7FF, 0, 0, 0)); // CLRDONE
    vecs.push_back(mk(1, 11'h7FE, 1, 0, 0, 11'h7FE, 0, 0, 1)); // LD on TC step
    vecs.push_back(mk(0, 11'h000, 1, 0, 0, 11'h7FF, 0, 0, 1));
    vecs.push_back(mk(1, 11'h100, 1, 0, 0, 11'h100, 0, 0, 1));
    vecs.push_back(mk(0, 11'h000, 1, 0, 0, 11'h101, 0, 0, 1));
    vecs.push_back(mk(1, 11'h7FF, 1, 1, 0, 11'h7FF, 0, 0, 1)); // LD masks one-shot stop
    vecs.push_back(mk(1, 11'h100, 1, 1, 0, 11'h100, 0, 0, 1));
    vecs.push_back(mk(1, 11'h7FF, 1, 0, 0, 11'h7FF, 0, 0, 1)); // back-to-back wraps
    vecs.push_back(mk(0, 11'h000, 1, 0, 0, 11'h7FF, 1, 0, 1));
    vecs.push_back(mk(0, 11'h000, 1, 0, 0, 11'h7FF, 1, 0, 1));
    vecs.push_back(mk(0, 11'h000, 1, 0, 0, 11'h7FF, 1, 0, 1));
    vecs.push_back(mk(0, 11'h000, 1, 0, 0, 11'h7FF, 1, 0, 1));
    vecs.push_back(mk(0, 11'h000, 0, 0, 0, 11'h7FF, 0, 0, 1));
    vecs.push_back(mk(0, 11'h000, 1, 1, 0, 11'h7FF, 1, 1, 0)); // STOP with DONE
    vecs.push_back(mk(1, 11'h7FF, 0, 1, 0, 11'h7FF, 0, 1, 1)); // LD keeps DONE
    vecs.push_back(mk(0, 11'h000, 1, 1, 1, 11'h7FF, 1, 1, 0)); // set beats clear
    vecs.push_back(mk(0, 11'h000, 0, 1, 1, 11'h7FF, 0, 0, 0));

    // Reset held with LD and EN active: everything stays cleared.
    RESETL = 1'b0;
    applyStimulus(1'b1, 11'h123, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge MasterClock);
    checkOutput("reset_held", 11'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    RESETL = 1'b1;
    applyStimulus(1'b0, 11'h000, 1'b0, 1'b0, 1'b0);
    @(negedge MasterClock);
    checkOutput("idle_after_reset", 11'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 11'h000, 1'b1, 1'b0, 1'b0);
    @(negedge MasterClock);
    checkOutput("idle_ignores_en", 11'h000, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ld, vecs[i].d, vecs[i].en, vecs[i].mode, vecs[i].clrDone);
      @(negedge MasterClock);
      checkOutput($sformatf("vec%0d", i), vecs[i].expQ, vecs[i].expTc, vecs[i].expPulse,
                  vecs[i].expDone, vecs[i].expRun);
    end

    // Asynchronous reset mid-RUN: Q clears before the next clock edge.
    applyStimulus(1'b1, 11'h010, 1'b1, 1'b0, 1'b0);
    @(negedge MasterClock);
    checkOutput("pre_reset_load", 11'h010, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 11'h000, 1'b1, 1'b0, 1'b0);
    @(negedge MasterClock);
    checkOutput("pre_reset_count", 11'h011, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 RESETL = 1'b0;
    #1 checkOutput("async_reset", 11'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge MasterClock);
    RESETL = 1'b1;
    repeat (2) @(negedge MasterClock);
    checkOutput("no_resume_without_ld", 11'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 11'h003, 1'b1, 1'b0, 1'b0);
    @(negedge MasterClock);
    checkOutput("resume_after_ld", 11'h003, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
